// File: rtl/stop_ctrl.sv
// Decode-stage flow controller: drives the PC stop_d/addr_d command
// and squashes branch/jump shadows, load-use hazards and post-halt slots.
module stop_ctrl #(
    parameter int         STALL_CYC = 1,
    parameter logic [5:0] ST_OP     = 6'd17
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] ins_d,
    input  logic        ins_v,
    input  logic        ex_load,
    input  logic [4:0]  ex_wreg,
    output logic [1:0]  stop_d,
    output logic [25:0] addr_d,
    output logic        bubble,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        SHADOW,
        HALT
    } st_t;

    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_JUMP = 2'b01;
    localparam logic [1:0] CMD_HOLD = 2'b10;
    localparam logic [1:0] CMD_BR   = 2'b11;

    st_t        st;
    st_t        st_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;

    logic is_jmp;
    logic is_br;
    logic is_halt;
    logic rt_src;
    logic rs_hit;
    logic rt_hit;
    logic hazard;

    assign op = ins_d[31:26];
    assign rs = ins_d[25:21];
    assign rt = ins_d[20:16];

    always_comb begin
        is_jmp  = ins_v && (op == 6'd40 || op == 6'd41);
        is_br   = ins_v && ((op >= 6'd32 && op <= 6'd35) || op == 6'd42);
        is_halt = ins_v && (op == 6'd63);
        rt_src  = (op == 6'd0) || (op >= 6'd32 && op <= 6'd35)
                  || (op == ST_OP);
    end

    // Jump target and halt bits overlap rs/rt, so those never compare.
    always_comb begin
        rs_hit = !is_jmp && !is_halt && (rs == ex_wreg);
        rt_hit = rt_src && (rt == ex_wreg);
        hazard = ins_v && ex_load && (ex_wreg != 5'd0)
                 && (rs_hit || rt_hit);
    end

    always_comb begin
        stop_d = CMD_RUN;
        addr_d = '0;
        bubble = 1'b0;
        halted = 1'b0;
        st_nx  = st;
        cnt_nx = cnt;
        if (!rstd) begin
            unique case (st)
                RUN: begin
                    if (hazard) begin
                        stop_d = CMD_HOLD;
                        bubble = 1'b1;
                        if (STALL_CYC > 1) begin
                            st_nx  = STALL;
                            cnt_nx = 2'(STALL_CYC - 1);
                        end
                    end else if (is_halt) begin
                        st_nx = HALT;
                    end else if (is_jmp) begin
                        stop_d = CMD_JUMP;
                        addr_d = ins_d[25:0];
                        st_nx  = SHADOW;
                        cnt_nx = 2'd1;
                    end else if (is_br) begin
                        stop_d = CMD_BR;
                        st_nx  = SHADOW;
                        cnt_nx = 2'd2;
                    end
                end
                STALL: begin
                    stop_d = CMD_HOLD;
                    bubble = 1'b1;
                    cnt_nx = cnt - 2'd1;
                    if (cnt == 2'd1) st_nx = RUN;
                end
                SHADOW: begin
                    // Must stay 00 so the PC can resolve the branch.
                    bubble = 1'b1;
                    cnt_nx = cnt - 2'd1;
                    if (cnt == 2'd1) st_nx = RUN;
                end
                HALT: begin
                    bubble = 1'b1;
                    halted = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            st  <= RUN;
            cnt <= 2'd0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_stop_ctrl.sv
// Randomized + directed bench for stop_ctrl, two instances
// (STALL_CYC=1 and 3) each checked against a cycle-count model.
module tb_stop_ctrl;

    logic        clk;
    logic        rstd;
    logic [31:0] ins_d;
    logic        ins_v;
    logic        ex_load;
    logic [4:0]  ex_wreg;

    logic [1:0]  sd_o [2];
    logic [25:0] ad_o [2];
    logic        bb_o [2];
    logic        hl_o [2];

    logic [1:0]  last_sd [2];
    logic [25:0] last_ad [2];
    logic        last_bb [2];
    logic        last_hl [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int hold;
        int shadow;
        bit halt;
    } mdl_t;

    mdl_t m [2];
    int   sc [2] = '{1, 3};

    stop_ctrl #(.STALL_CYC(1)) u_d1 (
        .clk(clk), .rstd(rstd), .ins_d(ins_d), .ins_v(ins_v),
        .ex_load(ex_load), .ex_wreg(ex_wreg),
        .stop_d(sd_o[0]), .addr_d(ad_o[0]),
        .bubble(bb_o[0]), .halted(hl_o[0])
    );

    stop_ctrl #(.STALL_CYC(3)) u_d3 (
        .clk(clk), .rstd(rstd), .ins_d(ins_d), .ins_v(ins_v),
        .ex_load(ex_load), .ex_wreg(ex_wreg),
        .stop_d(sd_o[1]), .addr_d(ad_o[1]),
        .bubble(bb_o[1]), .halted(hl_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs,
                                       input int rt, input int imm);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
        return w;
    endfunction

    task automatic model(input mdl_t cur, input int stall, input bit rst,
                         input logic [31:0] ins, input bit v, input bit ld,
                         input logic [4:0] wr,
                         output logic [1:0] sd, output logic [25:0] ad,
                         output bit bb, output bit hl, output mdl_t nxt);
        int  op, rs, rt;
        bit  jump, branch, halt, use_rs, use_rt, hazard;
        op = int'(ins[31:26]);
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        jump   = v && (op == 40 || op == 41);
        branch = v && ((op >= 32 && op <= 35) || op == 42);
        halt   = v && op == 63;
        use_rs = !(jump || halt);
        use_rt = op == 0 || (op >= 32 && op <= 35) || op == 17;
        hazard = v && ld && wr != 0 &&
                 ((use_rs && rs == int'(wr)) || (use_rt && rt == int'(wr)));
        sd = 2'b00; ad = '0; bb = 0; hl = 0;
        nxt = cur;
        if (rst) begin
            nxt.hold = 0; nxt.shadow = 0; nxt.halt = 0;
        end else if (cur.halt) begin
            bb = 1; hl = 1;
        end else if (cur.hold > 0) begin
            sd = 2'b10; bb = 1;
            nxt.hold = cur.hold - 1;
        end else if (cur.shadow > 0) begin
            bb = 1;
            nxt.shadow = cur.shadow - 1;
        end else if (hazard) begin
            sd = 2'b10; bb = 1;
            nxt.hold = stall - 1;
        end else if (halt) begin
            nxt.halt = 1;
        end else if (jump) begin
            sd = 2'b01; ad = ins[25:0];
            nxt.shadow = 1;
        end else if (branch) begin
            sd = 2'b11;
            nxt.shadow = 2;
        end
    endtask

    task automatic step(input bit rst, input logic [31:0] ins, input bit v,
                        input bit ld, input logic [4:0] wr);
        mdl_t        nm [2];
        logic [1:0]  sd;
        logic [25:0] ad;
        bit          bb, hl;
        @(negedge clk);
        rstd = rst; ins_d = ins; ins_v = v; ex_load = ld; ex_wreg = wr;
        #1;
        for (int i = 0; i < 2; i++) begin
            model(m[i], sc[i], rst, ins, v, ld, wr, sd, ad, bb, hl, nm[i]);
            check($sformatf("stop_d[%0d]", i), 32'(sd_o[i]), 32'(sd));
            check($sformatf("addr_d[%0d]", i), 32'(ad_o[i]), 32'(ad));
            check($sformatf("bubble[%0d]", i), 32'(bb_o[i]), 32'(bb));
            check($sformatf("halted[%0d]", i), 32'(hl_o[i]), 32'(hl));
            last_sd[i] = sd_o[i]; last_ad[i] = ad_o[i];
            last_bb[i] = bb_o[i]; last_hl[i] = hl_o[i];
        end
        @(posedge clk);
        m = nm;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 5'd0);
    endtask

    logic [31:0] w;

    initial begin
        rstd = 1; ins_d = '0; ins_v = 0; ex_load = 0; ex_wreg = '0;
        m[0] = '{0, 0, 0};
        m[1] = '{0, 0, 0};

        // reset with a jump present
        w = {6'd40, 26'h100};
        step(1, w, 1, 0, 0);
        check("rst_sd", 32'(last_sd[0]), 32'h0);
        check("rst_ad", 32'(last_ad[0]), 32'h0);
        step(1, w, 1, 0, 0);
        step(0, w, 1, 0, 0);
        check("rel_sd", 32'(last_sd[0]), 32'h1);
        check("rel_ad", 32'(last_ad[0]), 32'h100);
        drain(2);

        // jump shadow is one cycle, hides a branch
        step(0, {6'd40, 26'h400}, 1, 0, 0);
        check("jmp_bb", 32'(last_bb[0]), 32'h0);
        step(0, mk(32, 1, 2, 5), 1, 0, 0);
        check("jsh_sd", 32'(last_sd[0]), 32'h0);
        check("jsh_bb", 32'(last_bb[0]), 32'h1);
        step(0, mk(32, 1, 2, 5), 1, 0, 0);
        check("jnx_sd", 32'(last_sd[0]), 32'h3);
        drain(3);

        // beq then jr: 11 then two shadow cycles
        step(0, mk(32, 1, 2, 8), 1, 0, 0);
        step(0, mk(40, 0, 0, 0), 1, 0, 0);
        step(0, mk(41, 0, 0, 0), 1, 0, 0);
        check("bsh2_bb", 32'(last_bb[0]), 32'h1);
        step(0, mk(42, 7, 0, 0), 1, 0, 0);
        check("jr_sd", 32'(last_sd[0]), 32'h3);
        drain(3);

        // load-use on rt
        step(0, mk(0, 3, 5, 0), 1, 1, 5'd5);
        check("lu_sd", 32'(last_sd[1]), 32'h2);
        step(0, mk(0, 3, 5, 0), 1, 0, 5'd5);
        check("lu1_sd", 32'(last_sd[0]), 32'h0);
        check("lu3_sd", 32'(last_sd[1]), 32'h2);
        step(0, mk(0, 3, 5, 0), 1, 0, 5'd5);
        check("lu3b_sd", 32'(last_sd[1]), 32'h2);
        step(0, mk(0, 3, 5, 0), 1, 0, 5'd5);
        check("lu3c_sd", 32'(last_sd[1]), 32'h0);
        step(0, mk(0, 0, 0, 0), 1, 1, 5'd0);
        step(0, mk(40, 5, 5, 0), 1, 1, 5'd5);
        check("jnh_sd", 32'(last_sd[0]), 32'h1);
        drain(4);

        // hazard on a branch, then the branch
        step(0, mk(33, 4, 1, 0), 1, 1, 5'd4);
        step(0, mk(33, 4, 1, 0), 1, 0, 5'd4);
        check("hb_sd", 32'(last_sd[0]), 32'h3);
        drain(5);

        // halt then junk until reset
        step(0, mk(63, 0, 0, 0), 1, 0, 0);
        check("hlt_bb", 32'(last_bb[0]), 32'h0);
        step(0, mk(40, 1, 1, 1), 1, 0, 0);
        step(0, mk(32, 1, 1, 1), 1, 1, 5'd1);
        check("hlt_hl", 32'(last_hl[1]), 32'h1);
        check("hlt_sd", 32'(last_sd[1]), 32'h0);
        step(1, mk(40, 1, 1, 1), 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        check("hrel_hl", 32'(last_hl[0]), 32'h0);

        for (int k = 0; k < 3000; k++) begin
            int sel, op;
            sel = int'($urandom_range(0, 19));
            unique case (sel)
                0, 1, 2:  op = 0;
                3:        op = 17;
                4, 5:     op = 40;
                6:        op = 41;
                7, 8:     op = int'($urandom_range(32, 35));
                9:        op = 42;
                10:       op = ($urandom_range(0, 7) == 0) ? 63 : 8;
                default:  op = int'($urandom_range(0, 62));
            endcase
            w = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom));
            step($urandom_range(0, 15) == 0, w, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
